// File: rtl/bzled_pkg.sv
// Shared types and constants for the buzzer/RGB-LED pattern scheduler.
package bzled_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_e;

    localparam logic REQ_STATUS = 1'b0;
    localparam logic REQ_ALARM  = 1'b1;

    localparam int COLOR_W = 24;
    localparam int TONE_W  = 16;
    localparam int PHASE_W = 16;
    localparam int RPT_W   = 8;

    // A zero tone means silence, so the buzzer falls back to its idle setting.
    function automatic logic [31:0] bz_duty(input logic [TONE_W-1:0] tone,
                                            input logic [31:0]       idle);
        return (tone != '0) ? {16'd0, tone} : idle;
    endfunction

endpackage

// File: rtl/bzled_tick.sv
// Phase-tick prescaler: one-cycle pulse every TICK_DIV cycles, restarted by clr_i.
module bzled_tick #(
    parameter logic [31:0] TICK_DIV = 32'd50000
) (
    input  logic CLK,
    input  logic RST_n,
    input  logic clr_i,
    output logic tick_o
);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    assign tick_o = (cnt_q == TICK_DIV - 32'd1);

    always_comb begin
        cnt_d = cnt_q + 32'd1;
        if (clr_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bzled_sched.sv
// Two-requester blink/beep scheduler driving the PWM period/duty set inputs.
// Optional alarm preemption of a running status pattern: BZLED_SCHED_PREEMPT_EN.
module bzled_sched
    import bzled_pkg::*;
#(
    parameter logic [31:0] TICK_DIV   = 32'd50000,
    parameter logic [31:0] LED_PERIOD = 32'd255,
    parameter logic [31:0] BZ_IDLE    = 32'd0
) (
    input  logic               CLK,
    input  logic               RST_n,
    input  logic [1:0]         REQ_VALID,
    output logic [1:0]         REQ_READY,
    input  logic [COLOR_W-1:0] REQ_COLOR0,
    input  logic [COLOR_W-1:0] REQ_COLOR1,
    input  logic [TONE_W-1:0]  REQ_TONE0,
    input  logic [TONE_W-1:0]  REQ_TONE1,
    input  logic [PHASE_W-1:0] REQ_ON0,
    input  logic [PHASE_W-1:0] REQ_ON1,
    input  logic [PHASE_W-1:0] REQ_OFF0,
    input  logic [PHASE_W-1:0] REQ_OFF1,
    input  logic [RPT_W-1:0]   REQ_RPT0,
    input  logic [RPT_W-1:0]   REQ_RPT1,
    output logic [31:0]        FREQ_CNT_SET,
    output logic [31:0]        BZ_PUTY_SET,
    output logic [31:0]        LEDR_PUTY_SET,
    output logic [31:0]        LEDG_PUTY_SET,
    output logic [31:0]        LEDB_PUTY_SET,
    output logic               BUSY,
    output logic               GRANT_ID,
    output logic               DONE,
    output logic               ABORTED,
    output logic [1:0]         dbg_state_o
);

    // Handshake: a request transfers on any rising CLK edge where REQ_VALID[i]
    // and REQ_READY[i] are both high; REQ_READY is a combinational one-hot pulse.

    state_e             state_q;
    logic [COLOR_W-1:0] color_q;
    logic [TONE_W-1:0]  tone_q;
    logic [PHASE_W-1:0] on_q, off_q, ph_q;
    logic [RPT_W-1:0]   rpt_q;
    logic               grant_q, busy_q, done_q;
    logic [31:0]        led_r_q, led_g_q, led_b_q, bz_q;

    logic               sel, accept_idle, preempt, load;
    logic               tick, ph_done, tick_clr;
    logic [COLOR_W-1:0] req_color;
    logic [TONE_W-1:0]  req_tone;
    logic [PHASE_W-1:0] req_on, req_off;
    logic [RPT_W-1:0]   req_rpt_raw, req_rpt;

    // The alarm always wins arbitration, and a preemption is only ever by the alarm.
    assign sel         = REQ_VALID[1];
    assign req_color   = sel ? REQ_COLOR1 : REQ_COLOR0;
    assign req_tone    = sel ? REQ_TONE1  : REQ_TONE0;
    assign req_on      = sel ? REQ_ON1    : REQ_ON0;
    assign req_off     = sel ? REQ_OFF1   : REQ_OFF0;
    assign req_rpt_raw = sel ? REQ_RPT1   : REQ_RPT0;
    assign req_rpt     = (req_rpt_raw == '0) ? 8'd1 : req_rpt_raw;

`ifdef BZLED_SCHED_PREEMPT_EN
    assign preempt = (state_q != IDLE) && (grant_q == REQ_STATUS) && REQ_VALID[1];
`else
    assign preempt = 1'b0;
`endif

    // The cycle carrying DONE is not yet open for a new accept.
    assign accept_idle = (state_q == IDLE) && !done_q && (REQ_VALID != 2'b00);
    assign load        = accept_idle || preempt;
    assign REQ_READY   = load ? (sel ? 2'b10 : 2'b01) : 2'b00;

    // Zero-length phases end after one cycle; otherwise on the last tick.
    assign ph_done  = (ph_q == '0) || (tick && (ph_q == 16'd1));
    assign tick_clr = load || ((state_q != IDLE) && ph_done);

    bzled_tick #(.TICK_DIV(TICK_DIV)) u_tick (
        .CLK   (CLK),
        .RST_n (RST_n),
        .clr_i (tick_clr),
        .tick_o(tick)
    );

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= IDLE;
            color_q <= '0;
            tone_q  <= '0;
            on_q    <= '0;
            off_q   <= '0;
            ph_q    <= '0;
            rpt_q   <= '0;
            grant_q <= REQ_STATUS;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            led_r_q <= '0;
            led_g_q <= '0;
            led_b_q <= '0;
            bz_q    <= BZ_IDLE;
        end else begin
            done_q <= 1'b0;
            if (load) begin
                state_q <= ON;
                grant_q <= sel;
                busy_q  <= 1'b1;
                color_q <= req_color;
                tone_q  <= req_tone;
                on_q    <= req_on;
                off_q   <= req_off;
                ph_q    <= req_on;
                rpt_q   <= req_rpt;
                led_r_q <= {24'd0, req_color[23:16]};
                led_g_q <= {24'd0, req_color[15:8]};
                led_b_q <= {24'd0, req_color[7:0]};
                bz_q    <= bz_duty(req_tone, BZ_IDLE);
            end else begin
                case (state_q)
                    ON: begin
                        if (ph_done) begin
                            state_q <= OFF;
                            ph_q    <= off_q;
                            led_r_q <= '0;
                            led_g_q <= '0;
                            led_b_q <= '0;
                            bz_q    <= BZ_IDLE;
                        end else if (tick) begin
                            ph_q <= ph_q - 16'd1;
                        end
                    end
                    OFF: begin
                        if (ph_done) begin
                            if (rpt_q <= 8'd1) begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= ON;
                                rpt_q   <= rpt_q - 8'd1;
                                ph_q    <= on_q;
                                led_r_q <= {24'd0, color_q[23:16]};
                                led_g_q <= {24'd0, color_q[15:8]};
                                led_b_q <= {24'd0, color_q[7:0]};
                                bz_q    <= bz_duty(tone_q, BZ_IDLE);
                            end
                        end else if (tick) begin
                            ph_q <= ph_q - 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign FREQ_CNT_SET  = LED_PERIOD;
    assign BZ_PUTY_SET   = bz_q;
    assign LEDR_PUTY_SET = led_r_q;
    assign LEDG_PUTY_SET = led_g_q;
    assign LEDB_PUTY_SET = led_b_q;
    assign BUSY          = busy_q;
    assign GRANT_ID      = grant_q;
    assign DONE          = done_q || preempt;
    assign ABORTED       = preempt;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_bzled_sched.sv
// Self-checking bench for bzled_sched: per-cycle output timeline against a pattern model.
module tb_bzled_sched;

    localparam logic [31:0] TD = 32'd4;
    localparam logic [31:0] LP = 32'd255;
    localparam logic [31:0] BI = 32'd7;
    localparam int          W  = 166;

    logic        CLK = 1'b0;
    logic        RST_n = 1'b0;
    logic [1:0]  REQ_VALID = 2'b00;
    logic [1:0]  REQ_READY;
    logic [23:0] REQ_COLOR0 = '0, REQ_COLOR1 = '0;
    logic [15:0] REQ_TONE0 = '0, REQ_TONE1 = '0;
    logic [15:0] REQ_ON0 = '0, REQ_ON1 = '0, REQ_OFF0 = '0, REQ_OFF1 = '0;
    logic [7:0]  REQ_RPT0 = '0, REQ_RPT1 = '0;
    logic [31:0] FREQ_CNT_SET, BZ_PUTY_SET, LEDR_PUTY_SET, LEDG_PUTY_SET, LEDB_PUTY_SET;
    logic        BUSY, GRANT_ID, DONE, ABORTED;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];

    bzled_sched #(.TICK_DIV(TD), .LED_PERIOD(LP), .BZ_IDLE(BI)) dut (
        .CLK(CLK), .RST_n(RST_n),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_COLOR0(REQ_COLOR0), .REQ_COLOR1(REQ_COLOR1),
        .REQ_TONE0(REQ_TONE0), .REQ_TONE1(REQ_TONE1),
        .REQ_ON0(REQ_ON0), .REQ_ON1(REQ_ON1),
        .REQ_OFF0(REQ_OFF0), .REQ_OFF1(REQ_OFF1),
        .REQ_RPT0(REQ_RPT0), .REQ_RPT1(REQ_RPT1),
        .FREQ_CNT_SET(FREQ_CNT_SET), .BZ_PUTY_SET(BZ_PUTY_SET),
        .LEDR_PUTY_SET(LEDR_PUTY_SET), .LEDG_PUTY_SET(LEDG_PUTY_SET),
        .LEDB_PUTY_SET(LEDB_PUTY_SET),
        .BUSY(BUSY), .GRANT_ID(GRANT_ID), .DONE(DONE), .ABORTED(ABORTED),
        .dbg_state_o(dbg_state)
    );

    // Clock and watchdog.
    always #5 CLK = ~CLK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Snapshot layout: ready, busy, done, aborted, grant (only meaningful while busy), duties, period.
    function automatic logic [W-1:0] mk(input logic [1:0] rdy, input logic busy, input logic done,
                                        input logic ab, input logic grant, input logic [31:0] r,
                                        input logic [31:0] g, input logic [31:0] b,
                                        input logic [31:0] bz, input logic [31:0] freq);
        return {rdy, busy, done, ab, grant, r, g, b, bz, freq};
    endfunction

    function automatic logic [W-1:0] observed();
        return mk(REQ_READY, BUSY, DONE, ABORTED, BUSY ? GRANT_ID : 1'b0,
                  LEDR_PUTY_SET, LEDG_PUTY_SET, LEDB_PUTY_SET, BZ_PUTY_SET, FREQ_CNT_SET);
    endfunction

    function automatic logic [W-1:0] idle_snap();
        return mk(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, BI, LP);
    endfunction

    function automatic logic [W-1:0] on_snap(input logic [1:0] rdy, input logic done, input logic ab,
                                             input logic id, input logic [23:0] color,
                                             input logic [15:0] tone);
        logic [31:0] bz;
        bz = (tone == 16'd0) ? BI : {16'd0, tone};
        return mk(rdy, 1'b1, done, ab, id, {24'd0, color[23:16]}, {24'd0, color[15:8]},
                  {24'd0, color[7:0]}, bz, LP);
    endfunction

    // Reference model: one pattern as a cycle timeline derived from phase lengths and repeats.
    task automatic push_pattern(input logic id, input logic [23:0] color, input logic [15:0] tone,
                                input logic [15:0] on, input logic [15:0] off, input logic [7:0] rpt,
                                input bit with_accept);
        int rpt_eff, on_n, off_n;
        rpt_eff = (rpt == 8'd0) ? 1 : int'(rpt);
        on_n    = (on == 16'd0) ? 1 : int'(on) * int'(TD);
        off_n   = (off == 16'd0) ? 1 : int'(off) * int'(TD);
        if (with_accept) exp_q.push_back(mk(id ? 2'b10 : 2'b01, 1'b0, 1'b0, 1'b0, 1'b0,
                                            32'd0, 32'd0, 32'd0, BI, LP));
        for (int r = 0; r < rpt_eff; r++) begin
            for (int c = 0; c < on_n; c++) exp_q.push_back(on_snap(2'b00, 1'b0, 1'b0, id, color, tone));
            for (int c = 0; c < off_n; c++)
                exp_q.push_back(mk(2'b00, 1'b1, 1'b0, 1'b0, id, 32'd0, 32'd0, 32'd0, BI, LP));
        end
        exp_q.push_back(mk(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, BI, LP));
    endtask

    // Driver tasks. All are entered and left at posedge+1.
    task automatic set_req(input logic id, input logic [23:0] color, input logic [15:0] tone,
                           input logic [15:0] on, input logic [15:0] off, input logic [7:0] rpt);
        if (id) begin
            REQ_COLOR1 = color; REQ_TONE1 = tone; REQ_ON1 = on; REQ_OFF1 = off; REQ_RPT1 = rpt;
        end else begin
            REQ_COLOR0 = color; REQ_TONE0 = tone; REQ_ON0 = on; REQ_OFF0 = off; REQ_RPT0 = rpt;
        end
        REQ_VALID[id] = 1'b1;
    endtask

    task automatic scramble(input logic id);
        if (id) begin
            REQ_COLOR1 = 24'($urandom); REQ_TONE1 = 16'($urandom); REQ_ON1 = 16'($urandom);
            REQ_OFF1 = 16'($urandom); REQ_RPT1 = 8'($urandom);
        end else begin
            REQ_COLOR0 = 24'($urandom); REQ_TONE0 = 16'($urandom); REQ_ON0 = 16'($urandom);
            REQ_OFF0 = 16'($urandom); REQ_RPT0 = 8'($urandom);
        end
    endtask

    // Scoreboard: compare n cycles against the expected queue; drop VALID after each accept.
    task automatic drain(input string name, input int n);
        logic [1:0] rdy;
        for (int i = 0; i < n; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge CLK);
            rdy = REQ_READY;
            check_eq($sformatf("%s[%0d]", name, i), observed(), exp_q.pop_front());
            @(posedge CLK); #1;
            for (int k = 0; k < 2; k++) begin
                if (rdy[k]) begin
                    REQ_VALID[k] = 1'b0;
                    scramble(k[0]);
                end
            end
        end
    endtask

    task automatic idle_check(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            check_eq($sformatf("%s_idle[%0d]", name, i), observed(), idle_snap());
            @(posedge CLK); #1;
        end
    endtask

    initial begin
        logic        id;
        logic [23:0] color;
        logic [15:0] tone, on, off;
        logic [7:0]  rpt;

        // Reset values while reset is held.
        #12;
        check_eq("reset_outputs", observed(), idle_snap());
        check_eq("reset_state", W'(dbg_state), W'(0));
        @(posedge CLK); #1;
        RST_n = 1'b1;
        idle_check("post_reset", 2);

        // Reference pattern from the block's bring-up plan.
        set_req(1'b0, 24'h804020, 16'd100, 16'd2, 16'd3, 8'd2);
        push_pattern(1'b0, 24'h804020, 16'd100, 16'd2, 16'd3, 8'd2, 1'b1);
        drain("basic", exp_q.size());
        idle_check("basic", 1);

        // Simultaneous requests: alarm first, status right after the alarm's DONE.
        set_req(1'b1, 24'h11aa33, 16'd9, 16'd1, 16'd1, 8'd1);
        set_req(1'b0, 24'h0f0e0d, 16'd55, 16'd1, 16'd2, 8'd1);
        push_pattern(1'b1, 24'h11aa33, 16'd9, 16'd1, 16'd1, 8'd1, 1'b1);
        push_pattern(1'b0, 24'h0f0e0d, 16'd55, 16'd1, 16'd2, 8'd1, 1'b1);
        drain("arb", exp_q.size());
        idle_check("arb", 1);

        // Zero-length phases and zero repeat count.
        set_req(1'b0, 24'h123456, 16'd40, 16'd0, 16'd0, 8'd0);
        push_pattern(1'b0, 24'h123456, 16'd40, 16'd0, 16'd0, 8'd0, 1'b1);
        drain("zero", exp_q.size());
        idle_check("zero", 1);

        // Silent tone: LEDs lit while the buzzer stays at its idle value.
        set_req(1'b1, 24'hff0080, 16'd0, 16'd1, 16'd1, 8'd2);
        push_pattern(1'b1, 24'hff0080, 16'd0, 16'd1, 16'd1, 8'd2, 1'b1);
        drain("tone0", exp_q.size());
        idle_check("tone0", 1);

        // Alarm raised during the status ON phase.
        set_req(1'b0, 24'h203040, 16'd77, 16'd2, 16'd2, 8'd2);
`ifdef BZLED_SCHED_PREEMPT_EN
        exp_q.push_back(mk(2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, BI, LP));
        for (int c = 0; c < 3; c++) exp_q.push_back(on_snap(2'b00, 1'b0, 1'b0, 1'b0, 24'h203040, 16'd77));
        exp_q.push_back(on_snap(2'b10, 1'b1, 1'b1, 1'b0, 24'h203040, 16'd77));
        push_pattern(1'b1, 24'hc0ffee, 16'd300, 16'd1, 16'd1, 8'd1, 1'b0);
`else
        push_pattern(1'b0, 24'h203040, 16'd77, 16'd2, 16'd2, 8'd2, 1'b1);
        push_pattern(1'b1, 24'hc0ffee, 16'd300, 16'd1, 16'd1, 8'd1, 1'b1);
`endif
        drain("preempt_pre", 4);
        set_req(1'b1, 24'hc0ffee, 16'd300, 16'd1, 16'd1, 8'd1);
        drain("preempt", exp_q.size());
        idle_check("preempt", 1);

        // Reset in the middle of an OFF phase, then a fresh request.
        set_req(1'b0, 24'h998877, 16'd12, 16'd1, 16'd3, 8'd1);
        push_pattern(1'b0, 24'h998877, 16'd12, 16'd1, 16'd3, 8'd1, 1'b1);
        drain("rst_pre", 10);
        RST_n = 1'b0;
        #1;
        check_eq("rst_immediate", observed(), idle_snap());
        exp_q.delete();
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            check_eq($sformatf("rst_hold[%0d]", i), observed(), idle_snap());
        end
        @(posedge CLK); #1;
        RST_n = 1'b1;
        set_req(1'b0, 24'h010203, 16'd5, 16'd1, 16'd1, 8'd1);
        push_pattern(1'b0, 24'h010203, 16'd5, 16'd1, 16'd1, 8'd1, 1'b1);
        drain("rst_post", exp_q.size());
        idle_check("rst_post", 1);

        // Randomized single patterns.
        for (int t = 0; t < 12; t++) begin
            id    = 1'($urandom_range(0, 1));
            color = 24'($urandom);
            tone  = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
            on    = 16'($urandom_range(0, 3));
            off   = 16'($urandom_range(0, 3));
            rpt   = 8'($urandom_range(0, 3));
            set_req(id, color, tone, on, off, rpt);
            push_pattern(id, color, tone, on, off, rpt, 1'b1);
            drain($sformatf("rand%0d", t), exp_q.size());
            idle_check($sformatf("rand%0d", t), 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bzled_sched.md
# bzled_sched

Pattern scheduler for the buzzer/RGB-LED PWM peripheral. Two requesters, status (low priority) and alarm (high priority), each submit a blink/beep pattern. The block arbitrates between them and sequences ON/OFF phases on a millisecond tick. It drives the peripheral's period and duty set inputs directly, so software no longer reprograms them cycle by cycle.

## Interface
Parameters:
- TICK_DIV, 32'd50000: CLK cycles per phase tick (1 ms at 50 MHz); must be ≥ 2.
- LED_PERIOD, 32'd255: constant value driven on FREQ_CNT_SET.
- BZ_IDLE, 32'd0: BZ_PUTY_SET value driven when no tone is playing.

Ports:
- CLK, in, 1: clock.
- RST_n, in, 1: reset, asynchronous, active-low.
- REQ_VALID, in, 2: bit0 = status, bit1 = alarm. Held high until accepted.
- REQ_READY, out, 2: one-cycle accept pulse per requester.
- REQ_COLOR0, REQ_COLOR1, in, 24: {R, G, B} 8-bit duties for each requester.
- REQ_TONE0, REQ_TONE1, in, 16: buzzer period in CLK cycles; 0 means silent.
- REQ_ON0, REQ_ON1, REQ_OFF0, REQ_OFF1, in, 16: phase lengths in ticks.
- REQ_RPT0, REQ_RPT1, in, 8: number of ON/OFF cycles; 0 is treated as 1.
- FREQ_CNT_SET, out, 32: LED PWM period.
- BZ_PUTY_SET, out, 32: buzzer period.
- LEDR_PUTY_SET, LEDG_PUTY_SET, LEDB_PUTY_SET, out, 32: LED duties.
- BUSY, out, 1: a pattern is active.
- GRANT_ID, out, 1: requester being served; valid while BUSY.
- DONE, out, 1: one-cycle pulse when a pattern ends.
- ABORTED, out, 1: qualifies DONE; high when the pattern ended by preemption.

## Operation
- States: IDLE, ON, OFF.
- IDLE:
  - If any REQ_VALID is high, grant the alarm if REQ_VALID[1], otherwise the status requester.
  - Pulse REQ_READY[id], capture that requester's fields into the active registers, set GRANT_ID and BUSY, clear the tick prescaler, and enter ON.
- ON:
  - LED duties = {24'd0, color byte}.
  - BZ_PUTY_SET = {16'd0, tone} if tone ≠ 0, else BZ_IDLE.
  - Stay for ON ticks, then enter OFF.
- OFF:
  - LED duties = 0 and BZ_PUTY_SET = BZ_IDLE.
  - Stay for OFF ticks.
  - Then decrement the remaining-cycle count. If it reaches 0: pulse DONE (ABORTED=0), clear BUSY, enter IDLE. Otherwise enter ON.
- A phase length of 0 skips that phase in 1 cycle with no tick wait.
- FREQ_CNT_SET = LED_PERIOD always.
- All arithmetic is unsigned. The phase counter is 16 bits and the cycle counter 8 bits; neither wraps, because both are reloaded on load.
- Fields are captured at accept. Input changes after accept have no effect on the running pattern.
- A new request is accepted in the cycle after DONE at the earliest. REQ_READY is never asserted while BUSY, except on preemption.
- REQ_VALID dropping before accept is legal; the request is simply never served.

## Timing
- Reset values:
  - State = IDLE; REQ_READY = 0; BUSY = 0; GRANT_ID = 0; DONE = 0; ABORTED = 0.
  - LED duties = 0; BZ_PUTY_SET = BZ_IDLE; FREQ_CNT_SET = LED_PERIOD.
- Accept at cycle N (REQ_READY high at N). BUSY and the ON-phase outputs are registered and valid at N+1.
- A phase of L ticks lasts exactly L×TICK_DIV cycles, measured from its first output cycle.
- DONE is asserted in the cycle after the last OFF phase expires. At that same edge the outputs return to their idle values.
- Simultaneous REQ_VALID in IDLE: the alarm wins. The status request stays pending and is served next.
- Reset asserted mid-pattern: immediate return to reset values; no DONE pulse.

## Configuration
- Macro BZLED_SCHED_PREEMPT_EN defined:
  - While serving status (GRANT_ID=0) in ON or OFF, REQ_VALID[1] high aborts the pattern.
  - In that cycle: DONE=1, ABORTED=1, REQ_READY[1]=1, alarm fields captured, GRANT_ID←1, state←ON.
  - BUSY stays high throughout.
  - The aborted status request is not re-queued.
- Macro not defined: no preemption. The alarm waits for IDLE, and ABORTED is tied to 0.

## Structure
- Package bzled_pkg:
  - State enum (IDLE/ON/OFF).
  - REQ_STATUS = 1'b0, REQ_ALARM = 1'b1.
  - Field width constants: color 24, tone 16, phase 16, repeat 8.
- Sub-module bzled_tick:
  - TICK_DIV prescaler with synchronous clear input.
  - Outputs a one-cycle tick pulse.
  - The scheduler instantiates it once.

## Test plan
- TICK_DIV=4. Status request with color 0x80_40_20, tone 100, on 2, off 3, rpt 2 -> REQ_READY[0] pulse; LEDR=0x80, LEDG=0x40, LEDB=0x20, BZ=100 for 8 cycles, then idle values for 12 cycles, repeated twice; then one DONE pulse with ABORTED=0 and BUSY low.
- REQ_VALID=2'b11 in IDLE -> REQ_READY=2'b10 and GRANT_ID=1; status is served after the alarm's DONE.
- Request with on=0, off=0, rpt=0 -> one ON/OFF cycle taking 2 cycles total, then DONE.
- Tone 0 -> BZ_PUTY_SET stays at BZ_IDLE during ON while the LED duties are applied.
- With BZLED_SCHED_PREEMPT_EN, alarm raised in the status ON phase -> same cycle DONE=1, ABORTED=1, REQ_READY[1]=1; alarm outputs appear next cycle. Without the macro, the alarm is accepted only after the status pattern's DONE.
- RST_n low mid-OFF -> all outputs at reset values immediately; no DONE pulse; a new request is accepted after release.
